// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin grant scheduler with hold timeout and fixed inter-grant gap
module rr_grant_sched #(
  parameter int N_REQ    = 7,
  parameter int ID_W     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id,
  output logic             o_busy,
  output logic             o_timeout
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [ID_W-1:0] id_d;
  logic busy_d, to_d, found;
  logic [PW-1:0] ptr, ptr_d, win, cand;
  logic [CW-1:0] cnt, cnt_d;
  // round-robin pick: first requester after the last winner, wrapping modulo N_REQ
  always_comb begin
    win = ptr;
    cand = ptr;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!found && i_req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  // next state and next registered outputs; ptr holds the current winner during GRANT
  always_comb begin
    state_d = state;
    gnt_d = o_gnt;
    id_d = o_gnt_id;
    busy_d = o_busy;
    to_d = 1'b0;
    ptr_d = ptr;
    cnt_d = cnt;
    case (state)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_d = N_REQ'(1) << win;
        id_d = ID_W'(win) + ID_W'(1);
        busy_d = 1'b1;
        ptr_d = win;
        cnt_d = '0;
      end
      GRANT: begin
        cnt_d = cnt + 1'b1;
        if (!i_req[ptr] || (MAX_HOLD != 0 && cnt == HOLD_LAST)) begin
          state_d = GAP;
          gnt_d = '0;
          id_d = '0;
          busy_d = 1'b0;
          to_d = i_req[ptr];
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset restarts priority at requester 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_gnt <= '0;
      o_gnt_id <= '0;
      o_busy <= 1'b0;
      o_timeout <= 1'b0;
      ptr <= PW'(N_REQ - 1);
      cnt <= '0;
    end else begin
      state <= state_d;
      o_gnt <= gnt_d;
      o_gnt_id <= id_d;
      o_busy <= busy_d;
      o_timeout <= to_d;
      ptr <= ptr_d;
      cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rr_grant_sched.sv
// tb_rr_grant_sched: directed table and sequence checks for rr_grant_sched
module tb_rr_grant_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] req;
  logic [6:0] gnt;
  logic [3:0] id;
  logic busy, to;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic rst_n;
    logic [6:0] req;
    logic [6:0] gnt;
    logic [3:0] id;
    logic to;
  } vec_t;
  vec_t vecs[25];
  // 100 MHz clock
  always #5 clk = ~clk;
  rr_grant_sched #(.N_REQ(7), .ID_W(4), .MAX_HOLD(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt), .o_gnt_id(id), .o_busy(busy), .o_timeout(to)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string nm, input logic [6:0] g, input logic [3:0] i, input logic t);
    chk({nm, ".gnt"}, 32'(gnt), 32'(g));
    chk({nm, ".id"}, 32'(id), 32'(i));
    chk({nm, ".busy"}, 32'(busy), 32'(g != 7'h00));
    chk({nm, ".timeout"}, 32'(to), 32'(t));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1'b0, 7'h7F, 7'h00, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 7'h7F, 7'h00, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 7'h7F, 7'h01, 4'd1, 1'b0};
    vecs[3]  = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[5]  = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[6]  = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[7]  = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[8]  = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[9]  = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[10] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[11] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[12] = '{1'b1, 7'h09, 7'h01, 4'd1, 1'b0};
    vecs[13] = '{1'b1, 7'h08, 7'h00, 4'd0, 1'b0};
    vecs[14] = '{1'b1, 7'h08, 7'h00, 4'd0, 1'b0};
    vecs[15] = '{1'b1, 7'h08, 7'h08, 4'd4, 1'b0};
    vecs[16] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[17] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[18] = '{1'b1, 7'h01, 7'h01, 4'd1, 1'b0};
    vecs[19] = '{1'b1, 7'h41, 7'h01, 4'd1, 1'b0};
    vecs[20] = '{1'b1, 7'h41, 7'h01, 4'd1, 1'b0};
    vecs[21] = '{1'b1, 7'h01, 7'h01, 4'd1, 1'b0};
    vecs[22] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[23] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    vecs[24] = '{1'b1, 7'h00, 7'h00, 4'd0, 1'b0};
    rst_n = 1'b0;
    req = 7'h7F;
    for (int i = 0; i < 25; i++) begin
      rst_n = vecs[i].rst_n;
      req = vecs[i].req;
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].to);
    end
    // fairness: all requesting, each grantee drops its bit after 3 cycles
    rst_n = 1'b0;
    req = 7'h7F;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        chk_out($sformatf("fair%0d_c%0d", k, c), 7'(1 << (k % 7)), 4'((k % 7) + 1), 1'b0);
        if (c == 2) req = 7'h7F & ~7'(1 << (k % 7));
        @(negedge clk);
      end
      chk_out($sformatf("fair%0d_gap", k), 7'h00, 4'd0, 1'b0);
      req = (k == 7) ? 7'h00 : 7'h7F;
      @(negedge clk);
      chk_out($sformatf("fair%0d_idle", k), 7'h00, 4'd0, 1'b0);
      @(negedge clk);
    end
    // timeout with a lone requester, then re-grant to the same requester
    rst_n = 1'b0;
    req = 7'h00;
    @(negedge clk);
    rst_n = 1'b1;
    req = 7'h04;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      chk_out($sformatf("toA_c%0d", c), 7'h04, 4'd3, 1'b0);
      @(negedge clk);
    end
    chk_out("toA_gap", 7'h00, 4'd0, 1'b1);
    @(negedge clk);
    chk_out("toA_idle", 7'h00, 4'd0, 1'b0);
    @(negedge clk);
    chk_out("toA_regrant", 7'h04, 4'd3, 1'b0);
    req = 7'h00;
    @(negedge clk);
    chk_out("toA_release", 7'h00, 4'd0, 1'b0);
    @(negedge clk);
    // timeout while requester 5 waits: it wins next, revoked requester has lowest priority
    req = 7'h04;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      chk_out($sformatf("toB_c%0d", c), 7'h04, 4'd3, 1'b0);
      if (c == 4) req = 7'h24;
      @(negedge clk);
    end
    chk_out("toB_gap", 7'h00, 4'd0, 1'b1);
    @(negedge clk);
    chk_out("toB_idle", 7'h00, 4'd0, 1'b0);
    @(negedge clk);
    chk_out("toB_next", 7'h20, 4'd6, 1'b0);
    req = 7'h00;
    @(negedge clk);
    @(negedge clk);
    // asynchronous reset in the middle of a grant
    req = 7'h20;
    @(negedge clk);
    chk_out("rst_mid_grant", 7'h20, 4'd6, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 7'h00, 4'd0, 1'b0);
    req = 7'h30;
    @(negedge clk);
    chk_out("rst_held", 7'h00, 4'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_out("rst_after", 7'h10, 4'd5, 1'b0);
    req = 7'h00;
    @(negedge clk);
    chk_out("rst_after_gap", 7'h00, 4'd0, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_grant_sched.md
Name: rr_grant_sched

Overview:
- Round-robin scheduler sharing one resource between N_REQ requesters.
- Produces a registered one-hot grant vector and its binary grant index (requester k reported as k+1, 0 = no grant).
- The one-hot grant drives the shared datapath select lines; the binary index feeds status and debug logic.
- Enforces a maximum hold time per grant and a fixed dead gap between grants.

Parameters:
- N_REQ, 7, number of requesters (2..15).
- ID_W, 4, width of o_gnt_id; must satisfy 2^ID_W >= N_REQ+1.
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the timeout.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req  input  N_REQ  level requests; bit k = requester k, held high for the whole transaction.
- o_gnt  output  N_REQ  one-hot grant, registered; all zero when idle.
- o_gnt_id  output  ID_W  binary grant index: k+1 while requester k is granted, 0 otherwise.
- o_busy  output  1  high while any grant is active.
- o_timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset is asynchronous and active-low, with a single clock i_clk. While i_rst_n=0, all of the following hold immediately, regardless of the clock:
  - o_gnt=0, o_gnt_id=0, o_busy=0, o_timeout=0.
  - state=IDLE, hold counter=0, last-grant pointer ptr=N_REQ-1.
  - With ptr at N_REQ-1, requester 0 has highest priority first.
- States are IDLE, GRANT and GAP. All outputs decode from registers only; there are no combinational paths from i_req.
- IDLE:
  - With i_req=0, stay in IDLE.
  - Otherwise select the first set bit scanning ptr+1, ptr+2, … modulo N_REQ. Load the grant register, set ptr to the winner, clear the hold counter and move to GRANT.
  - Grant latency: o_gnt is visible in the cycle after the edge that sampled the request.
- GRANT:
  - o_gnt[w]=1, o_gnt_id=w+1, o_busy=1.
  - The hold counter increments every cycle; its width is enough to hold MAX_HOLD.
  - If i_req[w]=0 at an edge, go to GAP (normal release).
  - Else if MAX_HOLD!=0 and the counter equals MAX_HOLD-1, go to GAP with a timeout flag. o_gnt is therefore high for at most MAX_HOLD cycles.
  - Requests from other requesters never preempt the current grant.
- GAP:
  - Exactly one cycle with o_gnt=0, o_gnt_id=0 and o_busy=0.
  - o_timeout=1 in this cycle only if the tenure ended by timeout.
  - The next state is always IDLE.
- Minimum gap between consecutive grants is 2 cycles (GAP plus the IDLE arbitration cycle).
- Requests are sampled only in IDLE:
  - A request that rises and falls entirely within GRANT or GAP is never granted.
  - A requester that drops i_req in IDLE before sampling is not granted.
- After a timeout the revoked requester may keep i_req high. It re-competes with lowest priority because ptr equals its index.
- Reset mid-GRANT: the grant drops asynchronously, no o_timeout is produced, and priority restarts from requester 0.
- Invariants:
  - o_gnt is zero or one-hot.
  - o_gnt_id is consistent with o_gnt at all times.
  - o_busy equals the OR-reduction of o_gnt.

Test Plan:
- Reset: hold i_rst_n=0 with i_req=7'h7F -> all outputs 0. Release at edge t -> o_gnt=7'h01 and o_gnt_id=1 from cycle t+1.
- Single requester: i_req=7'h08 for 5 cycles, then 0 -> o_gnt=7'h08 and o_gnt_id=4 for exactly 5 cycles, then 2 cycles of o_gnt=0, o_timeout never set.
- Fairness: i_req=7'h7F held permanently, with each grantee releasing after 3 cycles -> o_gnt_id sequence 1,2,3,4,5,6,7,1,…, each tenure 3 cycles, each separated by exactly 2 idle cycles.
- Timeout: MAX_HOLD=16, i_req=7'h04 held for 40 cycles -> o_gnt_id=3 for exactly 16 cycles, o_timeout=1 for 1 cycle in the gap, then re-grant to 3 after 2 cycles; add i_req bit 5 during the first tenure -> the next grant goes to 6, not 3.
- Reset mid-grant: requester 5 granted, pull i_rst_n low between edges -> o_gnt=0 and o_gnt_id=0 before the next edge; after release with i_req=7'h30 -> grant to requester 4 (o_gnt_id=5).
- Short-pulse filtering: while requester 0 is granted, pulse i_req[6] for 2 cycles -> requester 6 is never granted and o_gnt_id never equals 7.
